// File: rtl/vproc_echo_resp_if.sv
// Start/done handshake bundle between the ELEM unit (master) and the echo responder (slave).
// Carries the start pulse and operand out, and the busy, done, result, tag and drop status back.
interface vproc_echo_resp_if #(
    parameter int unsigned TAG_W = 8
);
    logic              start_i;
    logic [31:0]       op_i;
    logic              busy_o;
    logic              done_o;
    logic [31:0]       result_o;
    logic [TAG_W-1:0]  tag_o;
    logic              drop_o;

    modport master (
        output start_i,
        output op_i,
        input  busy_o,
        input  done_o,
        input  result_o,
        input  tag_o,
        input  drop_o
    );

    modport slave (
        input  start_i,
        input  op_i,
        output busy_o,
        output done_o,
        output result_o,
        output tag_o,
        output drop_o
    );
endinterface

// File: rtl/vproc_echo_resp.sv
// Echo responder: captures the operand on start and returns a one-cycle done pulse LATENCY cycles later.
// No backpressure: a start seen while running is dropped and flagged on the sticky drop_o.
module vproc_echo_resp #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned TAG_W   = 8
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    input  logic             sync_rst_ni,
    vproc_echo_resp_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [15:0] CNT_INIT = 16'(LATENCY - 1);

    state_e             state_q;
    logic [15:0]        cnt_q;
    logic [31:0]        res_q;
    logic [TAG_W-1:0]   tag_q;
    logic               busy_q;
    logic               done_q;
    logic               drop_q;

    // Single sequential FSM; busy/done are registered alongside the state so no
    // output depends combinationally on start_i.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else if (!sync_rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            tag_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == S_RUN) begin
                if (bus.start_i) begin
                    drop_q <= 1'b1;
                end
                cnt_q <= cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    tag_q   <= tag_q + TAG_W'(1);
                end
            end else if (bus.start_i) begin
                // Accept from IDLE or DONE; accepting in DONE gives back-to-back service.
                res_q <= bus.op_i;
                if (LATENCY == 1) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    tag_q   <= tag_q + TAG_W'(1);
                end else begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                    cnt_q   <= CNT_INIT;
                end
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = res_q;
    assign bus.tag_o    = tag_q;
    assign bus.drop_o   = drop_q;

endmodule

// File: tb/tb_vproc_echo_resp.sv
// Bench for vproc_echo_resp: one LATENCY=4/TAG_W=2 instance and one LATENCY=1/TAG_W=8 instance,
// with a per-instance queue of expected completions checked whenever done_o fires.
module tb_vproc_echo_resp;

    localparam int unsigned LAT_A  = 4;
    localparam int unsigned TAGW_A = 2;
    localparam int unsigned LAT_B  = 1;
    localparam int unsigned TAGW_B = 8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic async_rst_ni;
    logic a_srst_n;
    logic b_srst_n;

    vproc_echo_resp_if #(.TAG_W(TAGW_A)) a_if ();
    vproc_echo_resp_if #(.TAG_W(TAGW_B)) b_if ();

    vproc_echo_resp #(.LATENCY(LAT_A), .TAG_W(TAGW_A)) u_dut_a (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .sync_rst_ni  (a_srst_n),
        .bus          (a_if)
    );

    vproc_echo_resp #(.LATENCY(LAT_B), .TAG_W(TAGW_B)) u_dut_b (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .sync_rst_ni  (b_srst_n),
        .bus          (b_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [7:0]  tag;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    logic [TAGW_A-1:0] a_tag_m;
    logic [TAGW_B-1:0] b_tag_m;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // Completion monitors: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (a_if.done_o === 1'b1) begin
            if (qa.size() == 0) begin
                check_eq("a_spurious_done", 64'(a_if.done_o), 64'd0);
            end else begin
                ea = qa.pop_front();
                check_eq("a_done_cycle", 64'(cyc), 64'(ea.due));
                check_eq("a_result", 64'(a_if.result_o), 64'(ea.res));
                check_eq("a_tag", 64'(a_if.tag_o), 64'(ea.tag));
            end
        end else if (qa.size() != 0 && qa[0].due <= cyc) begin
            check_eq("a_done_missing", 64'(a_if.done_o), 64'd1);
            void'(qa.pop_front());
        end
    end

    always @(negedge clk_i) begin
        if (b_if.done_o === 1'b1) begin
            if (qb.size() == 0) begin
                check_eq("b_spurious_done", 64'(b_if.done_o), 64'd0);
            end else begin
                eb = qb.pop_front();
                check_eq("b_done_cycle", 64'(cyc), 64'(eb.due));
                check_eq("b_result", 64'(b_if.result_o), 64'(eb.res));
                check_eq("b_tag", 64'(b_if.tag_o), 64'(eb.tag));
            end
        end else if (qb.size() != 0 && qb[0].due <= cyc) begin
            check_eq("b_done_missing", 64'(b_if.done_o), 64'd1);
            void'(qb.pop_front());
        end
    end

    task automatic a_issue(input logic [31:0] op);
        a_tag_m = a_tag_m + 1'b1;
        qa.push_back('{res: op, tag: 8'(a_tag_m), due: cyc + int'(LAT_A)});
        a_if.start_i = 1'b1;
        a_if.op_i    = op;
        tick();
        a_if.start_i = 1'b0;
        a_if.op_i    = $urandom;
    endtask

    task automatic b_issue(input logic [31:0] op);
        b_tag_m = b_tag_m + 1'b1;
        qb.push_back('{res: op, tag: 8'(b_tag_m), due: cyc + int'(LAT_B)});
        b_if.start_i = 1'b1;
        b_if.op_i    = op;
        tick();
        b_if.start_i = 1'b0;
        b_if.op_i    = $urandom;
    endtask

    task automatic a_zero_chk(input string name);
        check_eq(name, 64'({a_if.busy_o, a_if.done_o, a_if.result_o, a_if.tag_o, a_if.drop_o}), 64'd0);
    endtask

    task automatic a_sreset();
        a_srst_n = 1'b0;
        qa.delete();
        a_tag_m  = '0;
        tick();
        a_srst_n = 1'b1;
        a_zero_chk("a_after_sync_reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        async_rst_ni = 1'b0;
        a_srst_n     = 1'b1;
        b_srst_n     = 1'b1;
        a_if.start_i = 1'b0;
        a_if.op_i    = '0;
        b_if.start_i = 1'b0;
        b_if.op_i    = '0;
        a_tag_m      = '0;
        b_tag_m      = '0;
        repeat (2) tick();
        async_rst_ni = 1'b1;

        // Idle after reset: everything stays zero.
        for (int i = 0; i < 10; i++) begin
            tick();
            a_zero_chk("a_idle");
            check_eq("b_idle", 64'({b_if.busy_o, b_if.done_o, b_if.result_o, b_if.tag_o, b_if.drop_o}), 64'd0);
        end

        // Single operation: busy for three cycles, done in the fourth.
        a_issue(32'hDEADBEEF);
        for (int i = 1; i <= int'(LAT_A); i++) begin
            check_eq("a_busy_single", 64'(a_if.busy_o), (i < int'(LAT_A)) ? 64'd1 : 64'd0);
            tick();
        end
        check_eq("a_result_held", 64'(a_if.result_o), 64'hDEADBEEF);
        check_eq("a_tag_single", 64'(a_if.tag_o), 64'd1);
        check_eq("a_drop_clean", 64'(a_if.drop_o), 64'd0);
        check_eq("a_done_low_after", 64'(a_if.done_o), 64'd0);

        // Stray start while running is dropped and flagged.
        a_issue(32'hA5A5A5A5);
        tick();
        a_if.start_i = 1'b1;
        a_if.op_i    = 32'h12345678;
        check_eq("a_drop_before", 64'(a_if.drop_o), 64'd0);
        tick();
        a_if.start_i = 1'b0;
        check_eq("a_drop_set", 64'(a_if.drop_o), 64'd1);
        repeat (2) tick();
        check_eq("a_drop_sticky", 64'(a_if.drop_o), 64'd1);
        check_eq("a_result_not_stray", 64'(a_if.result_o), 64'hA5A5A5A5);
        check_eq("a_idle_after_stray", 64'(a_if.busy_o), 64'd0);

        // Back-to-back, each start in the previous DONE cycle; 2-bit tag wraps.
        a_sreset();
        for (int k = 0; k < 5; k++) begin
            a_issue(32'h1000_0000 + 32'(k));
            if (k < 4) repeat (LAT_A - 1) tick();
        end
        repeat (LAT_A + 1) tick();
        check_eq("a_tag_wrap_final", 64'(a_if.tag_o), 64'd1);
        check_eq("a_b2b_drop", 64'(a_if.drop_o), 64'd0);

        // Synchronous reset mid-operation aborts without a done pulse.
        a_issue(32'hCAFEF00D);
        tick();
        a_srst_n = 1'b0;
        qa.delete();
        a_tag_m  = '0;
        tick();
        a_srst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_zero_chk("a_after_mid_sreset");
            tick();
        end
        a_issue(32'h0BADF00D);
        repeat (LAT_A + 1) tick();
        check_eq("a_tag_after_sreset_op", 64'(a_if.tag_o), 64'd1);

        // Asynchronous reset mid-operation takes effect without a clock edge.
        a_issue(32'h55AA55AA);
        tick();
        #2;
        async_rst_ni = 1'b0;
        #1;
        check_eq("a_async_busy", 64'(a_if.busy_o), 64'd0);
        check_eq("a_async_result", 64'(a_if.result_o), 64'd0);
        check_eq("a_async_tag", 64'(a_if.tag_o), 64'd0);
        qa.delete();
        qb.delete();
        a_tag_m = '0;
        b_tag_m = '0;
        tick();
        async_rst_ni = 1'b1;
        repeat (LAT_A + 1) begin
            tick();
            a_zero_chk("a_after_async_reset");
        end

        // LATENCY=1: consecutive starts give consecutive dones, busy never rises.
        for (int i = 1; i <= 3; i++) begin
            b_issue(32'(i));
            check_eq("b_busy", 64'(b_if.busy_o), 64'd0);
        end
        repeat (3) tick();
        check_eq("b_drop", 64'(b_if.drop_o), 64'd0);
        check_eq("b_result_final", 64'(b_if.result_o), 64'd3);
        check_eq("b_tag_final", 64'(b_if.tag_o), 64'd3);

        check_eq("a_queue_drained", 64'(qa.size()), 64'd0);
        check_eq("b_queue_drained", 64'(qb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
